// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected engine: FSM states, accumulator
// sizing and the accumulator-to-output conversion (round, saturate, ReLU).
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_WRITE,
    S_DONE
  } fc_state_e;

  // Accumulator width (ACC_W): full-precision products summed over
  // in_neurons terms plus the pre-shifted bias, without overflow.
  function automatic int acc_width(input int in_neurons, input int data_w);
    return 2 * data_w + $clog2(in_neurons) + 1;
  endfunction

  // Round half up, arithmetic shift by frac_w, saturate to data_w signed,
  // then optional ReLU. Accumulators are sign-extended to 64 bits by callers.
  function automatic logic signed [63:0] round_sat_relu(
    input logic signed [63:0] acc,
    input int                 data_w,
    input int                 frac_w,
    input bit                 relu_en
  );
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r = acc;
    if (frac_w > 0) r = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    if (r > max_v) r = max_v;
    else if (r < min_v) r = min_v;
    if (relu_en && (r < 64'sd0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/fc_engine_if.sv
// Control/data bundle of fc_engine.
//   start, clr, in_data : requester -> engine
//   out_data, busy, done: engine -> requester
interface fc_engine_if #(
  parameter int IN_NEURONS  = 784,
  parameter int OUT_NEURONS = 128,
  parameter int DATA_W      = 16
);
  logic                          start;
  logic                          clr;
  logic [IN_NEURONS*DATA_W-1:0]  in_data;
  logic [OUT_NEURONS*DATA_W-1:0] out_data;
  logic                          busy;
  logic                          done;

  modport master (output start, clr, in_data, input out_data, busy, done);
  modport slave  (input start, clr, in_data, output out_data, busy, done);
endinterface

// File: rtl/fc_mac_lane.sv
// One neuron lane: accumulator loaded with the scaled bias, accumulating
// full-precision products, and the rounded/saturated result of the current sum.
//   ld_i   : load bias (bias_i << FRAC_W)
//   en_i   : accumulate x_i * w_i
//   res_o  : converted result of the accumulator
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 43,
  parameter int RELU_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] bias_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    prod  = (2*DATA_W)'(x_i) * (2*DATA_W)'(w_i);
    acc_d = acc_q;
    if (ld_i)      acc_d = ACC_W'(bias_i) <<< FRAC_W;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
    res_o = DATA_W'(round_sat_relu(64'(acc_q), DATA_W, FRAC_W, RELU_EN != 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/fc_engine.sv
// Fully-connected layer engine: LANES neurons per group, one input element
// per MAC cycle, results staged per group and published on DONE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/clr/in_data in, out_data/busy/done out
module fc_engine
  import fc_pkg::*;
#(
  parameter int    IN_NEURONS   = 784,
  parameter int    OUT_NEURONS  = 128,
  parameter int    DATA_W       = 16,
  parameter int    FRAC_W       = 8,
  parameter int    LANES        = 8,
  parameter int    RELU_EN      = 1,
  parameter string WEIGHTS_FILE = "weights.mem",
  parameter string BIASES_FILE  = "biases.mem"
) (
  input  logic         clk,
  input  logic         rst_n,
  fc_engine_if.slave   bus
);

  localparam int ACC_W  = acc_width(IN_NEURONS, DATA_W);
  localparam int GROUPS = (OUT_NEURONS + LANES - 1) / LANES;
  localparam int K_W    = (IN_NEURONS > 1) ? $clog2(IN_NEURONS) : 1;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int WA_W   = (IN_NEURONS*OUT_NEURONS > 1) ? $clog2(IN_NEURONS*OUT_NEURONS) : 1;
  localparam int BA_W   = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;

  logic signed [DATA_W-1:0] w_mem [IN_NEURONS*OUT_NEURONS];
  logic signed [DATA_W-1:0] b_mem [OUT_NEURONS];

  fc_state_e                state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [G_W-1:0]           grp_q, grp_d;
  logic signed [DATA_W-1:0] in_q [IN_NEURONS];
  logic signed [DATA_W-1:0] in_d [IN_NEURONS];
  logic signed [DATA_W-1:0] in_vec [IN_NEURONS];
  logic signed [DATA_W-1:0] lane_res [LANES];
  logic                     accept, lane_ld, lane_en, stage_we, out_we;

  for (genvar k = 0; k < IN_NEURONS; k++) begin : g_in
    assign in_vec[k] = bus.in_data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    grp_d    = grp_q;
    accept   = 1'b0;
    lane_ld  = 1'b0;
    lane_en  = 1'b0;
    stage_we = 1'b0;
    out_we   = 1'b0;
    if (state_q != S_IDLE && bus.clr) begin
      state_d = S_IDLE;
      k_d     = '0;
      grp_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start && !bus.clr) begin
          accept  = 1'b1;
          state_d = S_BIAS;
          k_d     = '0;
          grp_d   = '0;
        end
        S_BIAS: begin
          lane_ld = 1'b1;
          state_d = S_MAC;
        end
        S_MAC: begin
          lane_en = 1'b1;
          if (k_q == K_W'(IN_NEURONS - 1)) begin
            k_d     = '0;
            state_d = S_WRITE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        S_WRITE: begin
          stage_we = 1'b1;
          if (grp_q == G_W'(GROUPS - 1)) begin
            state_d = S_DONE;
          end else begin
            grp_d   = grp_q + 1'b1;
            state_d = S_BIAS;
          end
        end
        S_DONE: begin
          out_we  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    in_d = in_q;
    if (accept) in_d = in_vec;
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      grp_q   <= '0;
      in_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      grp_q   <= grp_d;
      in_q    <= in_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic                     valid;
    logic [WA_W-1:0]          w_idx;
    logic [BA_W-1:0]          b_idx;
    logic signed [DATA_W-1:0] w_sel, b_sel;

    // Lanes past the last neuron still run, fed with zeros.
    always_comb begin
      valid = (int'(grp_q) * LANES + l) < OUT_NEURONS;
      b_idx = BA_W'(int'(grp_q) * LANES + l);
      w_idx = WA_W'((int'(grp_q) * LANES + l) * IN_NEURONS + int'(k_q));
      w_sel = valid ? w_mem[w_idx] : '0;
      b_sel = valid ? b_mem[b_idx] : '0;
    end

    fc_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W),
      .RELU_EN(RELU_EN)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (lane_ld),
      .en_i  (lane_en),
      .bias_i(b_sel),
      .x_i   (in_q[k_q]),
      .w_i   (w_sel),
      .res_o (lane_res[l])
    );
  end

  for (genvar n = 0; n < OUT_NEURONS; n++) begin : g_neuron
    logic signed [DATA_W-1:0] stage_q, stage_d, out_q, out_d;

    always_comb begin
      stage_d = stage_q;
      out_d   = out_q;
      if (stage_we && grp_q == G_W'(n / LANES)) stage_d = lane_res[n % LANES];
      if (out_we) out_d = stage_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
        out_q   <= '0;
      end else begin
        stage_q <= stage_d;
        out_q   <= out_d;
      end
    end

    assign bus.out_data[n*DATA_W +: DATA_W] = out_q;
  end

endmodule

// File: tb/tb_fc_engine.sv
module tb_fc_engine;
  localparam int IN  = 4;
  localparam int OUT = 3;
  localparam int LN  = 2;
  localparam int DW  = 16;
  localparam int G   = (OUT + LN - 1) / LN;
  localparam int LAT = G * (IN + 2) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clr = 1'b0;
  logic [IN*DW-1:0] in_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic signed [DW-1:0] mw [IN*OUT];
  logic signed [DW-1:0] mb [OUT];
  logic [OUT*DW-1:0]    last_r = '0;
  logic [OUT*DW-1:0]    last_n = '0;

  always #5 clk = ~clk;

  fc_engine_if #(.IN_NEURONS(IN), .OUT_NEURONS(OUT), .DATA_W(DW)) bus_r ();
  fc_engine_if #(.IN_NEURONS(IN), .OUT_NEURONS(OUT), .DATA_W(DW)) bus_n ();

  assign bus_r.start = start;
  assign bus_r.clr = clr;
  assign bus_r.in_data = in_data;
  assign bus_n.start = start;
  assign bus_n.clr = clr;
  assign bus_n.in_data = in_data;

  fc_engine #(
    .IN_NEURONS(IN), .OUT_NEURONS(OUT), .DATA_W(DW), .FRAC_W(8), .LANES(LN),
    .RELU_EN(1), .WEIGHTS_FILE(""), .BIASES_FILE("")
  ) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  fc_engine #(
    .IN_NEURONS(IN), .OUT_NEURONS(OUT), .DATA_W(DW), .FRAC_W(8), .LANES(LN),
    .RELU_EN(0), .WEIGHTS_FILE(""), .BIASES_FILE("")
  ) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  always @(negedge clk) if (bus_r.done) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_w(input int i, input logic [DW-1:0] v);
    mw[i] = v;
    dut_r.w_mem[i] = v;
    dut_n.w_mem[i] = v;
  endtask

  task automatic set_b(input int i, input logic [DW-1:0] v);
    mb[i] = v;
    dut_r.b_mem[i] = v;
    dut_n.b_mem[i] = v;
  endtask

  task automatic fill(input logic [DW-1:0] wv, input logic [DW-1:0] bv);
    for (int i = 0; i < IN*OUT; i++) set_w(i, wv);
    for (int i = 0; i < OUT; i++) set_b(i, bv);
  endtask

  function automatic logic [DW-1:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[30] ? r[15:0] : {{5{r[10]}}, r[10:0]};
  endfunction

  function automatic logic [IN*DW-1:0] rnd_vec();
    return {rnd16(), rnd16(), rnd16(), rnd16()};
  endfunction

  // Reference: real-valued dot product in Q8 arithmetic, rounded half up.
  function automatic logic [OUT*DW-1:0] model(input logic [IN*DW-1:0] vec, input bit relu);
    logic [OUT*DW-1:0]    res;
    longint               acc, r;
    logic signed [DW-1:0] x;
    logic [DW-1:0]        u;
    res = '0;
    for (int n = 0; n < OUT; n++) begin
      acc = longint'(mb[n]) * 256;
      for (int k = 0; k < IN; k++) begin
        x = DW'(vec >> (k*DW));
        acc += longint'(x) * longint'(mw[n*IN+k]);
      end
      r = (acc + 128) >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      u = DW'(r);
      res = res | ((OUT*DW)'(u) << (n*DW));
    end
    return res;
  endfunction

  task automatic run_op(input logic [IN*DW-1:0] vec, input string tag, input bit poke);
    int n;
    int d0;
    logic [OUT*DW-1:0] er, en;
    er = model(vec, 1'b1);
    en = model(vec, 1'b0);
    d0 = done_cnt;
    @(negedge clk); in_data = vec; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    check({tag, ":busy_hi"}, 64'(bus_r.busy), 64'd1);
    if (poke) in_data = ~vec;
    while (!bus_r.done && n < 4*LAT) begin
      @(negedge clk); n++;
      if (poke) start = (n % 3 == 0);
    end
    check({tag, ":latency"}, 64'(n), 64'(LAT));
    check({tag, ":done_nr"}, 64'(bus_n.done), 64'd1);
    if (poke) start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, ":out_relu"}, 64'(bus_r.out_data), 64'(er));
    check({tag, ":out_norelu"}, 64'(bus_n.out_data), 64'(en));
    check({tag, ":idle_flags"}, 64'({bus_r.busy, bus_r.done}), 64'd0);
    @(negedge clk);
    check({tag, ":still_idle"}, 64'(bus_r.busy), 64'd0);
    check({tag, ":one_done"}, 64'(done_cnt - d0), 64'd1);
    in_data = vec;
    last_r = er;
    last_n = en;
  endtask

  logic [IN*DW-1:0] v;
  int d0;

  initial begin
    repeat (2) @(negedge clk);
    check("rst:out_relu", 64'(bus_r.out_data), 64'd0);
    check("rst:out_norelu", 64'(bus_n.out_data), 64'd0);
    check("rst:flags", 64'({bus_r.busy, bus_r.done}), 64'd0);
    rst_n = 1'b1;

    fill(16'h0100, 16'h0000);
    run_op({16'h0400, 16'h0300, 16'h0200, 16'h0100}, "unit_w", 1'b0);
    check("unit_w:const", 64'(bus_r.out_data), 64'({3{16'h0A00}}));

    fill(16'hFF00, 16'h0000);
    run_op({16'h0400, 16'h0300, 16'h0200, 16'h0100}, "neg_w", 1'b0);
    check("neg_w:relu_const", 64'(bus_r.out_data), 64'd0);
    check("neg_w:norelu_const", 64'(bus_n.out_data), 64'({3{16'hF600}}));

    fill(16'h7FFF, 16'h0000);
    run_op({4{16'h7FFF}}, "sat", 1'b0);
    check("sat:const", 64'(bus_r.out_data), 64'({3{16'h7FFF}}));

    fill(16'h0080, 16'h0000);
    run_op({16'h0000, 16'h0000, 16'h0000, 16'h0001}, "rnd_half", 1'b0);
    check("rnd_half:const", 64'(bus_n.out_data), 64'({3{16'h0001}}));
    fill(16'h007F, 16'h0000);
    run_op({16'h0000, 16'h0000, 16'h0000, 16'h0001}, "rnd_below", 1'b0);
    check("rnd_below:const", 64'(bus_n.out_data), 64'd0);

    for (int unsigned it = 0; it < 8; it++) begin
      for (int i = 0; i < IN*OUT; i++) set_w(i, rnd16());
      for (int i = 0; i < OUT; i++) set_b(i, rnd16());
      run_op(rnd_vec(), $sformatf("rand%0d", it), it[0]);
    end

    // Abort partway through the first group.
    d0 = done_cnt;
    @(negedge clk); in_data = rnd_vec(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr:busy_lo", 64'(bus_r.busy), 64'd0);
    check("clr:out_kept", 64'(bus_r.out_data), 64'(last_r));
    repeat (20) @(negedge clk);
    check("clr:no_done", 64'(done_cnt - d0), 64'd0);
    check("clr:out_kept_late", 64'(bus_n.out_data), 64'(last_n));

    @(negedge clk); start = 1'b1; clr = 1'b1;
    @(negedge clk); start = 1'b0; clr = 1'b0;
    check("clr_vs_start:idle", 64'(bus_r.busy), 64'd0);

    // Reset in the middle of MAC, checked between clock edges.
    @(negedge clk); in_data = rnd_vec(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst:pre_busy", 64'(bus_r.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst:out_relu", 64'(bus_r.out_data), 64'd0);
    check("mid_rst:out_norelu", 64'(bus_n.out_data), 64'd0);
    check("mid_rst:flags", 64'({bus_r.busy, bus_r.done, bus_n.busy, bus_n.done}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    v = rnd_vec();
    run_op(v, "post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
